// File: rtl/accumulator_n.sv
// Key-driven accumulator: each debounced press of Run_Accumulate adds or subtracts SW into a
// WIDTH-bit running total; shows a sticky overflow flag, busy state, press count and the total on HEX.
module accumulator_n #(
    parameter int WIDTH    = 16,
    parameter int SW_WIDTH = 10,
    parameter int SATURATE = 0
) (
    input  logic                Clk,
    input  logic                Reset_Clear,
    input  logic                Run_Accumulate,
    input  logic                Sub,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [9:0]          LED,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               run_s_q, run_s_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   sw_ext;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    assign sw_ext = WIDTH'(SW);
    assign sum    = {1'b0, acc_q} + {1'b0, sw_ext};
    assign diff   = {1'b0, acc_q} - {1'b0, sw_ext};

    always_comb begin
        sync1_d = Run_Accumulate;
        run_s_d = sync1_q;
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (!run_s_q) state_d = ACCUM;
            end
            ACCUM: begin
                state_d = HOLD;
                count_d = count_q + 8'd1;
                if (Sub) begin
                    // diff[WIDTH] is the borrow out of the WIDTH-bit subtraction
                    if (diff[WIDTH]) ovf_d = 1'b1;
                    acc_d = (diff[WIDTH] && SATURATE != 0) ? '0 : diff[WIDTH-1:0];
                end else begin
                    if (sum[WIDTH]) ovf_d = 1'b1;
                    acc_d = (sum[WIDTH] && SATURATE != 0) ? '1 : sum[WIDTH-1:0];
                end
            end
            HOLD: begin
                // Only a release seen on the synchronised key re-arms a press
                if (run_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == HOLD);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_Clear) begin
            sync1_q <= 1'b1;
            run_s_q <= 1'b1;
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            run_s_q <= run_s_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign LED = {ovf_q, busy_q, count_q};

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [23:0] acc_ext;
    logic [6:0]  hex_vec [6];

    assign acc_ext = 24'(acc_q);

    for (genvar gi = 0; gi < 6; gi++) begin : g_hex
        assign hex_vec[gi] = seg7(acc_ext[gi*4 +: 4]);
    end

    assign HEX0 = hex_vec[0];
    assign HEX1 = hex_vec[1];
    assign HEX2 = hex_vec[2];
    assign HEX3 = hex_vec[3];
    assign HEX4 = hex_vec[4];
    assign HEX5 = hex_vec[5];

endmodule

// File: tb/tb_accumulator_n.sv
// Drives four accumulator_n variants (16/12-bit, wrap/saturate) with shared key/switch stimulus
// and compares LED/HEX against an arithmetic reference model after every press phase.
module tb_accumulator_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_n;
    logic       sub;
    logic [9:0] sw;

    logic [9:0] led [4];
    logic [6:0] hex [4][6];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int W = (gi < 2) ? 16 : 12;
        localparam int S = gi % 2;
        accumulator_n #(.WIDTH(W), .SW_WIDTH(10), .SATURATE(S)) u_dut (
            .Clk           (clk),
            .Reset_Clear   (rst_n),
            .Run_Accumulate(run_n),
            .Sub           (sub),
            .SW            (sw),
            .LED           (led[gi]),
            .HEX0          (hex[gi][0]),
            .HEX1          (hex[gi][1]),
            .HEX2          (hex[gi][2]),
            .HEX3          (hex[gi][3]),
            .HEX4          (hex[gi][4]),
            .HEX5          (hex[gi][5])
        );
    end

    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference model: one entry per DUT instance
    int     wid [4] = '{16, 16, 12, 12};
    bit     sat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    longint m_acc [4];
    int     m_cnt [4];
    bit     m_ovf [4];

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
    endfunction

    function automatic void model_apply(input int v, input bit s);
        for (int i = 0; i < 4; i++) begin
            longint mx;
            longint r;
            mx = (longint'(1) << wid[i]) - 1;
            if (!s) begin
                r = m_acc[i] + v;
                if (r > mx) begin
                    m_ovf[i] = 1'b1;
                    r = sat[i] ? mx : r - (mx + 1);
                end
            end else begin
                r = m_acc[i] - v;
                if (r < 0) begin
                    m_ovf[i] = 1'b1;
                    r = sat[i] ? 0 : r + (mx + 1);
                end
            end
            m_acc[i] = r;
            m_cnt[i] = (m_cnt[i] + 1) % 256;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit busy);
        for (int i = 0; i < 4; i++) begin
            logic [9:0]  e_led;
            logic [41:0] e_hex;
            logic [41:0] o_hex;
            e_led = {m_ovf[i], busy, 8'(m_cnt[i])};
            for (int d = 0; d < 6; d++) begin
                e_hex[d*7 +: 7] = seg_ref(4'(m_acc[i] >> (4 * d)));
                o_hex[d*7 +: 7] = hex[i][d];
            end
            check($sformatf("%s led[%0d]", tag, i), 64'(led[i]), 64'(e_led));
            check($sformatf("%s hex[%0d]", tag, i), 64'(o_hex), 64'(e_hex));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run_n = 1'b1;
        tick();
        tick();
        model_reset();
        check_all("reset", 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("after_reset", 1'b0);
    endtask

    task automatic release_key();
        run_n = 1'b1;
        tick();
        tick();
        check_all("release+2", 1'b1);
        tick();
        check_all("release+3", 1'b0);
    endtask

    // One press: operand is only valid in the ACCUM cycle; garbage elsewhere must be ignored
    task automatic press(input logic [9:0] v, input logic s, input int hold_extra);
        run_n = 1'b0;
        sw    = 10'($urandom);
        sub   = 1'($urandom);
        tick();
        tick();
        tick();
        check_all("pre_update", 1'b0);
        sw  = v;
        sub = s;
        tick();
        model_apply(int'(v), s);
        check_all("update", 1'b1);
        sw  = 10'($urandom);
        sub = 1'($urandom);
        if (hold_extra > 0) begin
            repeat (hold_extra) tick();
            check_all("held", 1'b1);
        end
        release_key();
        $display("press sw=%03h sub=%0d -> acc16=%04h acc12=%03h/%03h cnt=%0d", v, s,
                 m_acc[0][15:0], m_acc[2][11:0], m_acc[3][11:0], m_cnt[0]);
    endtask

    initial begin
        rst_n = 1'b0;
        run_n = 1'b1;
        sub   = 1'b0;
        sw    = '0;
        model_reset();
        @(negedge clk);

        do_reset();
        check("reset led8", 64'(led[0][8]), 64'(1'b0));

        // Add sequence
        press(10'h00F, 1'b0, 0);
        press(10'h001, 1'b0, 0);
        check("add hex1", 64'(hex[0][1]), 64'(7'b1111001));
        check("add hex0", 64'(hex[0][0]), 64'(7'b1000000));
        check("add count", 64'(led[0][7:0]), 64'(8'd2));

        // Held key: one update only
        do_reset();
        press(10'h1FF, 1'b0, 46);
        check("held hex2..0", 64'({hex[0][2], hex[0][1], hex[0][0]}),
              64'({7'b1111001, 7'b0001110, 7'b0001110}));
        check("held count", 64'(led[0][7:0]), 64'(8'd1));

        // Wrap vs saturate at 12 bits
        do_reset();
        repeat (4) press(10'h3FF, 1'b0, 0);
        press(10'h005, 1'b0, 0);
        check("wrap12 hex", 64'({hex[2][2], hex[2][1], hex[2][0]}),
              64'({7'b1000000, 7'b1000000, 7'b1111001}));
        check("sat12 hex", 64'({hex[3][2], hex[3][1], hex[3][0]}),
              64'({7'b0001110, 7'b0001110, 7'b0001110}));
        check("wrap12 ovf", 64'(led[2][9]), 64'(1'b1));
        check("sat12 ovf", 64'(led[3][9]), 64'(1'b1));

        // Subtract from zero
        do_reset();
        press(10'h003, 1'b1, 0);
        check("sub wrap hex", 64'({hex[0][3], hex[0][2], hex[0][1], hex[0][0]}),
              64'({7'b0001110, 7'b0001110, 7'b0001110, 7'b0100001}));
        check("sub sat hex0", 64'(hex[1][0]), 64'(7'b1000000));
        check("sub ovf", 64'({led[0][9], led[1][9]}), 64'(2'b11));

        // Reset landing on the ACCUM edge, key held through release
        do_reset();
        run_n = 1'b0;
        tick();
        tick();
        tick();
        sw    = 10'h1FF;
        sub   = 1'b0;
        rst_n = 1'b0;
        tick();
        model_reset();
        check_all("reset_in_accum", 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_all("rst_release+3", 1'b0);
        tick();
        model_apply(10'h1FF, 1'b0);
        check_all("rst_release+4", 1'b1);
        check("rst_mid count", 64'(led[0][7:0]), 64'(8'd1));
        release_key();

        // Exact boundaries: reach 2^12-1 and subtract to exactly 0
        do_reset();
        repeat (4) press(10'h3FF, 1'b0, 0);
        press(10'h003, 1'b0, 0);
        check("max12 no ovf", 64'({led[2][9], led[3][9]}), 64'(2'b00));
        repeat (3) press(10'h3FF, 1'b1, 0);
        press(10'h3FF, 1'b1, 0);
        press(10'h003, 1'b1, 0);
        check("zero no ovf", 64'({led[0][9], led[1][9], led[2][9], led[3][9]}), 64'(4'b0000));

        // Counter wrap does not flag overflow
        do_reset();
        repeat (256) press(10'h000, 1'b0, 0);
        check("cnt wrap", 64'(led[0][7:0]), 64'(8'd0));
        check("cnt wrap ovf", 64'(led[0][9]), 64'(1'b0));

        // Random presses
        do_reset();
        for (int k = 0; k < 40; k++) begin
            press(10'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
